ov_capture_window: RTL and testbench
====================================

// Module: ov_capture_window
// PURPOSE
//  Camera-side capture front end, p_clk domain, directly upstream of the CLK-domain pixel/CDC stage.
//  Uses camera VSYNC/HREF framing to pair bytes into 16-bit pixels, MSB first, and tracks x/y.
//  Crops each frame to the active window and emits it with frame/line markers.
//  Flags malformed lines and frames.
// PARAMETERS
//  FrameWidth        640  pixels per full camera line (2*FrameWidth bytes while HREF high)
//  FrameHeight       480  lines per full frame
//  ActiveFrameWidth  512  cropped window width
//  ActiveFrameHeight 384  cropped window height
//  XOffset           64   first active column; XOffset+ActiveFrameWidth <= FrameWidth
//  YOffset           48   first active line; YOffset+ActiveFrameHeight <= FrameHeight
//  PixelBitWidth     16   output pixel width, fixed at 2 bytes
// PORTS
//  p_clk        in   1   camera pixel clock; all logic on rising edge
//  RST          in   1   synchronous reset, active-low
//  i_enable     in   1   capture permitted; high after SCCB setup completes
//  i_vsync      in   1   camera VSYNC; high = vertical blank
//  i_href       in   1   camera HREF; high = valid bytes on i_data
//  i_data       in   8   camera data byte
//  o_pixel      out  16  cropped pixel {first byte, second byte}
//  o_valid      out  1   o_pixel valid, one p_clk
//  o_sof        out  1   with o_valid: first pixel of frame (x=XOffset, y=YOffset)
//  o_eol        out  1   with o_valid: last active pixel of line
//  o_frame_done out  1   1-cycle pulse, VSYNC rise ending a frame
//  o_line_err   out  1   1-cycle pulse, line byte count != 2*FrameWidth
//  o_frame_err  out  1   1-cycle pulse with o_frame_done if line count != FrameHeight
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, byte phase 0, state S_IDLE.
//   RST low mid-line discards the partial pixel.
//  Input stage: i_vsync/i_href/i_data registered once. Edges are detected on the registered copies.
//  FSM:
//   S_IDLE: wait for i_enable=1 -> S_SYNC.
//   S_SYNC: wait for VSYNC fall (blank->active) -> S_FRAME; clear x, y, phase.
//   S_FRAME: capture. VSYNC rise -> pulse o_frame_done (+o_frame_err) -> S_SYNC.
//   i_enable=0 in any state -> S_IDLE next cycle; o_valid forced 0; no done pulse.
//  Byte pairing: phase clears on HREF rise and toggles per registered HREF-high byte.
//   phase0 byte -> pixel[15:8]; phase1 byte -> pixel[7:0], x++.
//  Latency: first byte sampled at edge n, second at n+1; o_valid high after edge n+2 (register to output).
//  Crop: o_valid iff XOffset<=x<XOffset+ActiveFrameWidth and YOffset<=y<YOffset+ActiveFrameHeight.
//   o_eol when x==XOffset+ActiveFrameWidth-1.
//  HREF fall: y++, x cleared. If byte count != 2*FrameWidth, pulse o_line_err.
//   A trailing odd byte is dropped, never output.
//  Saturation: x stops at FrameWidth and y at FrameHeight. Excess bytes/lines produce no output
//   (x>=FrameWidth also sets line error).
//  VSYNC rise while HREF high: line aborted, no o_line_err. o_frame_done wins; y compared before clear.
//  Counter widths: $clog2(FrameWidth+1), $clog2(FrameHeight+1), $clog2(2*FrameWidth+1) for byte count.
//   Comparisons unsigned.
//  o_valid/o_sof/o_eol/pulses never asserted in S_IDLE/S_SYNC.
// STRUCTURE
//  Shared package: FSM state localparams (S_IDLE/S_SYNC/S_FRAME), counter-width localparams, crop-bound helpers.
//  One sub-module: ov_edge_detect (registered level + rise/fall pulses), instanced for VSYNC and HREF.
//  Otherwise flat: FSM, byte pairer, x/y/byte counters, crop compare, output register.
// TESTING
//  1 Reset, i_enable=1, one 640x480 frame, byte k of line y = (y+k)&8'hFF
//     -> exactly 196608 o_valid; first o_pixel={8'hB0,8'hB1} (y=48,x=64); 1 o_sof; 384 o_eol;
//     o_frame_done once, o_frame_err=0.
//  2 i_enable=0 throughout a full frame -> zero o_valid, zero pulses.
//     Enable raised mid-frame -> capture starts only after next VSYNC fall.
//  3 Line 100 carries 1279 bytes -> o_line_err pulse at HREF fall; last byte dropped;
//     line 101 first active pixel still at x=64.
//  4 VSYNC rises after line 200 (HREF low) -> o_frame_done + o_frame_err;
//     next full frame produces 196608 valid pixels, y restarted at 0.
//  5 RST low for one cycle mid-line 60 -> all outputs 0 next cycle;
//     no o_valid until VSYNC fall after i_enable; then clean frame.
//  6 Back-to-back pixels at line boundary x=575 -> o_eol on that pixel only;
//     no o_valid for x=576..639 or lines >=432.

Source files
------------

// File: rtl/ov_capture_window_pkg.sv
// rtl/ov_capture_window_pkg.sv - capture window states, default geometry and crop helpers
package ov_capture_window_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  localparam int unsigned FRAME_WIDTH         = 640;
  localparam int unsigned FRAME_HEIGHT        = 480;
  localparam int unsigned ACTIVE_FRAME_WIDTH  = 512;
  localparam int unsigned ACTIVE_FRAME_HEIGHT = 384;
  localparam int unsigned X_OFFSET            = 64;
  localparam int unsigned Y_OFFSET            = 48;
  localparam int unsigned PIXEL_BIT_WIDTH     = 16;

  // Counters must be able to hold their saturation value itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic logic in_window(input int unsigned pos, input int unsigned first,
                                     input int unsigned len);
    return (pos >= first) && (pos < first + len);
  endfunction

  function automatic logic is_last(input int unsigned pos, input int unsigned first,
                                   input int unsigned len);
    return pos == first + len - 1;
  endfunction

endpackage

// File: rtl/ov_edge_detect.sv
// rtl/ov_edge_detect.sv - registered copy of a framing strobe with one-cycle rise/fall pulses
module ov_edge_detect (
  input  logic p_clk,
  input  logic RST,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic level_q, level_d;
  logic prev_q, prev_d;

  always_comb begin
    level_d = i_sig;
    prev_d  = level_q;
  end

  always_ff @(posedge p_clk) begin
    if (!RST) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = level_q & ~prev_q;
  assign o_fall  = ~level_q & prev_q;

endmodule

// File: rtl/ov_capture_window.sv
// rtl/ov_capture_window.sv - pairs camera bytes into 16-bit pixels, crops to the active window,
// and flags malformed lines and frames
module ov_capture_window
  import ov_capture_window_pkg::*;
#(
  parameter int unsigned FrameWidth        = FRAME_WIDTH,
  parameter int unsigned FrameHeight       = FRAME_HEIGHT,
  parameter int unsigned ActiveFrameWidth  = ACTIVE_FRAME_WIDTH,
  parameter int unsigned ActiveFrameHeight = ACTIVE_FRAME_HEIGHT,
  parameter int unsigned XOffset           = X_OFFSET,
  parameter int unsigned YOffset           = Y_OFFSET
) (
  input  logic        p_clk,
  input  logic        RST,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [15:0] o_pixel,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_frame_done,
  output logic        o_line_err,
  output logic        o_frame_err
);

  localparam int XW = cnt_width(FrameWidth);
  localparam int YW = cnt_width(FrameHeight);
  localparam int BW = cnt_width(2 * FrameWidth);
  localparam logic [XW-1:0] X_MAX = XW'(FrameWidth);
  localparam logic [YW-1:0] Y_MAX = YW'(FrameHeight);
  localparam logic [BW-1:0] B_MAX = BW'(2 * FrameWidth);

  logic vs_level, vs_rise, vs_fall;
  logic hr_level, hr_rise, hr_fall;

  ov_edge_detect u_vsync_edge (
    .p_clk  (p_clk),
    .RST    (RST),
    .i_sig  (i_vsync),
    .o_level(vs_level),
    .o_rise (vs_rise),
    .o_fall (vs_fall)
  );

  ov_edge_detect u_href_edge (
    .p_clk  (p_clk),
    .RST    (RST),
    .i_sig  (i_href),
    .o_level(hr_level),
    .o_rise (hr_rise),
    .o_fall (hr_fall)
  );

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      hi_q, hi_d;
  logic            phase_q, phase_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     pixel_q, pixel_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            done_q, done_d;
  logic            line_err_q, line_err_d;
  logic            frame_err_q, frame_err_d;

  logic            byte_phase;
  logic [BW-1:0]   byte_base;
  logic            ovf_base;

  always_comb begin
    state_d     = state_q;
    data_d      = i_data;
    hi_d        = hi_q;
    phase_d     = phase_q;
    x_d         = x_q;
    y_d         = y_q;
    byte_cnt_d  = byte_cnt_q;
    ovf_d       = ovf_q;
    pixel_d     = pixel_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    done_d      = 1'b0;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;
    // The byte that coincides with the HREF rise always opens a new pixel.
    byte_phase  = hr_rise ? 1'b0 : phase_q;
    byte_base   = hr_rise ? '0 : byte_cnt_q;
    ovf_base    = hr_rise ? 1'b0 : ovf_q;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (vs_fall) begin
          state_d    = S_FRAME;
          x_d        = '0;
          y_d        = '0;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      S_FRAME: begin
        if (vs_rise) begin
          // An open line is abandoned silently; the frame verdict uses y as it stands.
          state_d     = S_SYNC;
          done_d      = 1'b1;
          frame_err_d = (y_q != Y_MAX);
        end else if (hr_level && !vs_level) begin
          byte_cnt_d = (byte_base == B_MAX) ? B_MAX : byte_base + 1'b1;
          ovf_d      = ovf_base | (x_q == X_MAX);
          if (!byte_phase) begin
            hi_d    = data_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q != X_MAX) begin
              x_d = x_q + 1'b1;
              if (in_window(32'(x_q), XOffset, ActiveFrameWidth) &&
                  in_window(32'(y_q), YOffset, ActiveFrameHeight)) begin
                valid_d = 1'b1;
                pixel_d = {hi_q, data_q};
                sof_d   = (32'(x_q) == XOffset) && (32'(y_q) == YOffset);
                eol_d   = is_last(32'(x_q), XOffset, ActiveFrameWidth);
              end
            end
          end
        end else if (hr_fall) begin
          line_err_d = (byte_cnt_q != B_MAX) || ovf_q;
          x_d        = '0;
          phase_d    = 1'b0;
          if (y_q != Y_MAX) y_d = y_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_enable) begin
      state_d     = S_IDLE;
      valid_d     = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      done_d      = 1'b0;
      line_err_d  = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge p_clk) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      done_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      byte_cnt_q  <= byte_cnt_d;
      ovf_q       <= ovf_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      done_q      <= done_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_pixel      = pixel_q;
  assign o_valid      = valid_q;
  assign o_sof        = sof_q;
  assign o_eol        = eol_q;
  assign o_frame_done = done_q;
  assign o_line_err   = line_err_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_ov_capture_window.sv
// tb/tb_ov_capture_window.sv - randomized frame bench for ov_capture_window with a pixel-list model
module tb_ov_capture_window;

  localparam int FW = 16;
  localparam int FH = 12;
  localparam int AW = 8;
  localparam int AH = 6;
  localparam int XO = 4;
  localparam int YO = 3;

  logic        p_clk = 1'b0;
  logic        RST = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_vsync = 1'b1;
  logic        i_href = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic [15:0] o_pixel;
  logic        o_valid, o_sof, o_eol, o_frame_done, o_line_err, o_frame_err;

  always #5 p_clk = ~p_clk;

  ov_capture_window #(
    .FrameWidth(FW), .FrameHeight(FH), .ActiveFrameWidth(AW),
    .ActiveFrameHeight(AH), .XOffset(XO), .YOffset(YO)
  ) dut (
    .p_clk(p_clk), .RST(RST), .i_enable(i_enable), .i_vsync(i_vsync),
    .i_href(i_href), .i_data(i_data), .o_pixel(o_pixel), .o_valid(o_valid),
    .o_sof(o_sof), .o_eol(o_eol), .o_frame_done(o_frame_done),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err)
  );

  int checks = 0;
  int passes = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int exp_done, exp_ferr, exp_lerr;
  int obs_done = 0, obs_ferr = 0, obs_lerr = 0, obs_stray = 0;
  int ob, bd, bf, bl;

  always @(negedge p_clk) begin
    if (RST) begin
      if (o_valid) obs_q.push_back({o_sof, o_eol, o_pixel});
      if (o_frame_done) obs_done++;
      if (o_frame_err) obs_ferr++;
      if (o_line_err) obs_lerr++;
      if ((!o_valid && (o_sof || o_eol)) || (o_frame_err && !o_frame_done)) obs_stray++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_score;
    exp_q.delete();
    exp_done = 0;
    exp_ferr = 0;
    exp_lerr = 0;
    ob = obs_q.size();
    bd = obs_done;
    bf = obs_ferr;
    bl = obs_lerr;
  endtask

  task automatic drive_line(input int y, input int nbytes, input int mode,
                            input bit model_en, input int gap);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int k = 0; k < nbytes; k++) begin
      v = (mode == 0) ? 8'((y + k) & 255) : 8'($urandom);
      b.push_back(v);
      @(posedge p_clk); #1;
      i_href = 1'b1;
      i_data = v;
    end
    @(posedge p_clk); #1;
    i_href = 1'b0;
    i_data = 8'($urandom);
    repeat (gap - 1) @(posedge p_clk);
    if (model_en) begin
      for (int p = 0; p < nbytes / 2; p++)
        if (p < FW && y < FH && p >= XO && p < XO + AW && y >= YO && y < YO + AH)
          exp_q.push_back({(p == XO && y == YO), (p == XO + AW - 1), b[2*p], b[2*p+1]});
      if (nbytes != 2 * FW) exp_lerr++;
    end
  endtask

  task automatic drive_frame(input int nlines, input int sp_line, input int sp_bytes,
                             input int mode, input bit model_en, input int gap_max,
                             input int en_line);
    @(posedge p_clk); #1;
    i_vsync = 1'b1;
    repeat (4) @(posedge p_clk);
    #1 i_vsync = 1'b0;
    repeat (3) @(posedge p_clk);
    for (int l = 0; l < nlines; l++) begin
      if (l == en_line) begin
        #1 i_enable = 1'b1;
      end
      drive_line(l, (l == sp_line) ? sp_bytes : 2 * FW, mode, model_en,
                 $urandom_range(gap_max, 1));
    end
    @(posedge p_clk); #1;
    i_vsync = 1'b1;
    if (model_en) begin
      exp_done++;
      if (nlines != FH) exp_ferr++;
    end
    repeat (8) @(posedge p_clk);
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge p_clk);
    #1;
    checks++;
    if ({o_valid, o_sof, o_eol} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {o_valid, o_sof, o_eol});
    else passes++;
    checks++;
    if (o_pixel !== 16'h0000) $display("FAIL reset_pixel got %h want 0000", o_pixel);
    else passes++;
    checks++;
    if ({o_frame_done, o_line_err, o_frame_err} !== 3'b000)
      $display("FAIL reset_pulses got %b want 000", {o_frame_done, o_line_err, o_frame_err});
    else passes++;
    RST = 1'b1;
  endtask

  task automatic test_full_frame;
    int n_sof, n_eol;
    logic [17:0] first_exp;
    logic [7:0] b0, b1;
    b0 = 8'(YO + 2 * XO);
    b1 = 8'(YO + 2 * XO + 1);
    first_exp = {1'b1, 1'b0, b0, b1};
    start_score();
    i_enable = 1'b1;
    drive_frame(FH, -1, 0, 0, 1, 4, -1);
    checks++;
    if (obs_q.size() - ob !== AW * AH)
      $display("FAIL full_count got %0d want %0d", obs_q.size() - ob, AW * AH);
    else passes++;
    checks++;
    if (obs_q.size() <= ob) $display("FAIL full_first got none want %h", first_exp);
    else if (obs_q[ob] !== first_exp)
      $display("FAIL full_first got %h want %h", obs_q[ob], first_exp);
    else passes++;
    n_sof = 0;
    n_eol = 0;
    for (int i = ob; i < obs_q.size(); i++) begin
      n_sof += int'(obs_q[i][17]);
      n_eol += int'(obs_q[i][16]);
    end
    checks++;
    if (n_sof !== 1) $display("FAIL full_sof got %0d want 1", n_sof);
    else passes++;
    checks++;
    if (n_eol !== AH) $display("FAIL full_eol got %0d want %0d", n_eol, AH);
    else passes++;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL full_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if ({obs_done - bd, obs_ferr - bf, obs_lerr - bl} !== {32'sd1, 32'sd0, 32'sd0})
      $display("FAIL full_pulses got done=%0d ferr=%0d lerr=%0d want 1/0/0",
               obs_done - bd, obs_ferr - bf, obs_lerr - bl);
    else passes++;
  endtask

  task automatic test_disabled;
    start_score();
    i_enable = 1'b0;
    drive_frame(FH, -1, 0, 1, 0, 3, -1);
    checks++;
    if ((obs_q.size() - ob) !== 0 || obs_done - bd !== 0 || obs_ferr - bf !== 0 || obs_lerr - bl !== 0)
      $display("FAIL disabled_quiet got valid=%0d done=%0d ferr=%0d lerr=%0d want all 0",
               obs_q.size() - ob, obs_done - bd, obs_ferr - bf, obs_lerr - bl);
    else passes++;
    drive_frame(FH, -1, 0, 1, 0, 3, YO + 1);
    drive_frame(FH, -1, 0, 1, 1, 3, -1);
    checks++;
    if ((obs_q.size() - ob) !== exp_q.size())
      $display("FAIL midenable_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL midenable_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_done - bd !== exp_done || obs_ferr - bf !== exp_ferr || obs_lerr - bl !== exp_lerr)
      $display("FAIL midenable_pulses got %0d/%0d/%0d want %0d/%0d/%0d", obs_done - bd,
               obs_ferr - bf, obs_lerr - bl, exp_done, exp_ferr, exp_lerr);
    else passes++;
  endtask

  task automatic test_line_length;
    start_score();
    drive_frame(FH, YO + 2, 2 * FW - 1, 1, 1, 3, -1);
    drive_frame(FH, YO + 1, 2 * FW + 3, 1, 1, 3, -1);
    checks++;
    if ((obs_q.size() - ob) !== exp_q.size())
      $display("FAIL linelen_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL linelen_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_lerr - bl !== exp_lerr)
      $display("FAIL linelen_lerr got %0d want %0d", obs_lerr - bl, exp_lerr);
    else passes++;
    checks++;
    if (obs_done - bd !== exp_done || obs_ferr - bf !== exp_ferr)
      $display("FAIL linelen_frame got %0d/%0d want %0d/%0d", obs_done - bd,
               obs_ferr - bf, exp_done, exp_ferr);
    else passes++;
  endtask

  task automatic test_short_frame;
    start_score();
    drive_frame(YO + AH - 2, -1, 0, 1, 1, 3, -1);
    drive_frame(FH, -1, 0, 1, 1, 3, -1);
    checks++;
    if ((obs_q.size() - ob) !== exp_q.size())
      $display("FAIL shortframe_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL shortframe_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_done - bd !== exp_done || obs_ferr - bf !== exp_ferr || obs_lerr - bl !== exp_lerr)
      $display("FAIL shortframe_pulses got %0d/%0d/%0d want %0d/%0d/%0d", obs_done - bd,
               obs_ferr - bf, obs_lerr - bl, exp_done, exp_ferr, exp_lerr);
    else passes++;
  endtask

  task automatic test_reset_midline;
    start_score();
    i_enable = 1'b1;
    @(posedge p_clk); #1;
    i_vsync = 1'b1;
    repeat (4) @(posedge p_clk);
    #1 i_vsync = 1'b0;
    repeat (3) @(posedge p_clk);
    for (int l = 0; l < YO + 2; l++) drive_line(l, 2 * FW, 1, 0, 2);
    for (int k = 0; k < 2 * FW; k++) begin
      @(posedge p_clk); #1;
      RST = (k != FW + 1);
      i_href = 1'b1;
      i_data = 8'($urandom);
      if (k == FW + 2) begin
        checks++;
        if ({o_valid, o_sof, o_eol, o_frame_done, o_line_err, o_frame_err, o_pixel} !== 22'd0)
          $display("FAIL midreset_outputs got v=%b p=%h pulses=%b want all 0", o_valid,
                   o_pixel, {o_sof, o_eol, o_frame_done, o_line_err, o_frame_err});
        else passes++;
        ob = obs_q.size();
        bd = obs_done;
        bf = obs_ferr;
        bl = obs_lerr;
      end
    end
    @(posedge p_clk); #1;
    i_href = 1'b0;
    repeat (2) @(posedge p_clk);
    for (int l = YO + 3; l < FH; l++) drive_line(l, 2 * FW, 1, 0, 2);
    @(posedge p_clk); #1;
    i_vsync = 1'b1;
    repeat (8) @(posedge p_clk);
    drive_frame(FH, -1, 0, 1, 1, 3, -1);
    checks++;
    if ((obs_q.size() - ob) !== exp_q.size())
      $display("FAIL midreset_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL midreset_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (obs_done - bd !== exp_done || obs_ferr - bf !== exp_ferr || obs_lerr - bl !== exp_lerr)
      $display("FAIL midreset_pulses got %0d/%0d/%0d want %0d/%0d/%0d", obs_done - bd,
               obs_ferr - bf, obs_lerr - bl, exp_done, exp_ferr, exp_lerr);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int n_eol;
    start_score();
    drive_frame(FH, -1, 0, 1, 1, 1, -1);
    checks++;
    if ((obs_q.size() - ob) !== exp_q.size())
      $display("FAIL b2b_count got %0d want %0d", obs_q.size() - ob, exp_q.size());
    else passes++;
    n_eol = 0;
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      n_eol += int'(obs_q[ob+i][16]);
      checks++;
      if (obs_q[ob+i] !== exp_q[i])
        $display("FAIL b2b_pix[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (n_eol !== AH) $display("FAIL b2b_eol got %0d want %0d", n_eol, AH);
    else passes++;
    checks++;
    if (obs_done - bd !== exp_done || obs_ferr - bf !== exp_ferr || obs_lerr - bl !== exp_lerr)
      $display("FAIL b2b_pulses got %0d/%0d/%0d want %0d/%0d/%0d", obs_done - bd,
               obs_ferr - bf, obs_lerr - bl, exp_done, exp_ferr, exp_lerr);
    else passes++;
    checks++;
    if (obs_stray !== 0) $display("FAIL stray_strobes got %0d want 0", obs_stray);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_disabled();
    test_line_length();
    test_short_frame();
    test_reset_midline();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
